// File: rtl/cle_pkg.sv
// Shared widths, depth and FSM state encoding for the two-port SRAM arbiter.
package cle_pkg;
  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 8;
  localparam int SRAM_DEPTH = 1024;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SRAM_DEPTH - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } arb_state_e;
endpackage

// File: rtl/cle_sram_arb_if.sv
// Requester and SRAM signal bundle for cle_sram_arb.
// Handshake: reqN (with weN/addrN/wdataN) is held until gntN; a cycle with reqN && gntN
// is the transfer. A read transfer returns rdata with a one-cycle rvalidN pulse two cycles later.
interface cle_sram_arb_if;
  import cle_pkg::*;

  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] sram_a;
  logic [DATA_W-1:0] sram_d;
  logic              sram_wen;
  logic [DATA_W-1:0] sram_q;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_q,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, sram_a, sram_d, sram_wen
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_q,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, sram_a, sram_d, sram_wen
  );
endinterface

// File: rtl/cle_rr_pick.sv
// Two-input picker: round-robin (MODE=0) or fixed priority to input 0 (MODE=1).
module cle_rr_pick #(
  parameter int MODE = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);
  // last_q = 1 means input 1 holds the most recent grant, so input 0 wins the next tie.
  logic last_q, last_d;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (MODE == 1) begin
        gnt_o[0] = req_i[0];
        gnt_o[1] = req_i[1] & ~req_i[0];
      end else if (req_i == 2'b11) begin
        gnt_o = last_q ? 2'b01 : 2'b10;
      end else begin
        gnt_o = req_i;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt_o[0])      last_d = 1'b0;
    else if (gnt_o[1]) last_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) last_q <= 1'b1;
    else        last_q <= last_d;
  end
endmodule

// File: rtl/cle_sram_arb.sv
// Two-requester SRAM arbiter: fills the SRAM with INIT_VAL after reset, then grants
// one access per cycle and returns read data with a fixed latency of two cycles.
module cle_sram_arb
  import cle_pkg::*;
#(
  parameter int                ARB_MODE = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = 8'h00
) (
  input  logic            clk,
  input  logic            reset,
  cle_sram_arb_if.slave   bus,
  output logic            init_done,
  output arb_state_e      dbg_state_o
);
  arb_state_e        state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              init_done_q;
  logic [ADDR_W-1:0] sram_a_q;
  logic [DATA_W-1:0] sram_d_q;
  logic              sram_wen_q;
  logic [DATA_W-1:0] rdata_q;
  logic              tag_v_q;
  logic              tag_id_q;
  logic [1:0]        rvalid_q;

  logic [1:0]        gnt;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // Grants open one cycle after the last init write so init_done and the first grant coincide.
  cle_rr_pick #(.MODE(ARB_MODE)) u_pick (
    .clk   (clk),
    .reset (reset),
    .en_i  (init_done_q),
    .req_i ({bus.req1, bus.req0}),
    .gnt_o (gnt)
  );

  always_comb begin
    win_we    = gnt[1] ? bus.we1    : bus.we0;
    win_addr  = gnt[1] ? bus.addr1  : bus.addr0;
    win_wdata = gnt[1] ? bus.wdata1 : bus.wdata0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      sram_a_q    <= '0;
      sram_d_q    <= '0;
      sram_wen_q  <= 1'b1;
      rdata_q     <= '0;
      tag_v_q     <= 1'b0;
      tag_id_q    <= 1'b0;
      rvalid_q    <= 2'b00;
    end else begin
      tag_v_q  <= 1'b0;
      rvalid_q <= 2'b00;
      // Second tag stage: the read address was presented this cycle, so sram_q is valid now.
      if (tag_v_q) begin
        rdata_q  <= bus.sram_q;
        rvalid_q <= tag_id_q ? 2'b10 : 2'b01;
      end
      case (state_q)
        ST_INIT: begin
          sram_a_q   <= cnt_q;
          sram_d_q   <= INIT_VAL;
          sram_wen_q <= 1'b0;
          if (cnt_q == LAST_ADDR) state_q <= ST_ARB;
          else                    cnt_q   <= cnt_q + ADDR_W'(1);
        end
        ST_ARB: begin
          init_done_q <= 1'b1;
          if (|gnt) begin
            sram_a_q   <= win_addr;
            sram_d_q   <= win_wdata;
            sram_wen_q <= ~win_we;
            tag_v_q    <= ~win_we;
            tag_id_q   <= gnt[1];
          end else begin
            sram_wen_q <= 1'b1;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign bus.gnt0     = gnt[0];
  assign bus.gnt1     = gnt[1];
  assign bus.rvalid0  = rvalid_q[0];
  assign bus.rvalid1  = rvalid_q[1];
  assign bus.rdata    = rdata_q;
  assign bus.sram_a   = sram_a_q;
  assign bus.sram_d   = sram_d_q;
  assign bus.sram_wen = sram_wen_q;
  assign init_done    = init_done_q;
  assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_cle_sram_arb.sv
// Bench for cle_sram_arb: round-robin instance with a behavioural SRAM and reference
// model, plus a fixed-priority instance sharing the same request inputs.
module tb_cle_sram_arb;
  import cle_pkg::*;

  localparam logic [7:0] INIT_V = 8'h3C;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cle_sram_arb_if if0 ();
  cle_sram_arb_if if_f ();
  logic       init_done, init_done_f;
  arb_state_e st0, st_f;

  cle_sram_arb #(.ARB_MODE(0), .INIT_VAL(INIT_V)) u_dut (
    .clk(clk), .reset(reset), .bus(if0.slave), .init_done(init_done), .dbg_state_o(st0)
  );
  cle_sram_arb #(.ARB_MODE(1), .INIT_VAL(INIT_V)) u_fix (
    .clk(clk), .reset(reset), .bus(if_f.slave), .init_done(init_done_f), .dbg_state_o(st_f)
  );

  assign if_f.req0   = if0.req0;
  assign if_f.req1   = if0.req1;
  assign if_f.we0    = if0.we0;
  assign if_f.we1    = if0.we1;
  assign if_f.addr0  = if0.addr0;
  assign if_f.addr1  = if0.addr1;
  assign if_f.wdata0 = if0.wdata0;
  assign if_f.wdata1 = if0.wdata1;
  assign if_f.sram_q = 8'h00;

  // Behavioural SRAM: write on rising edge, read combinationally from the registered address.
  logic [7:0] sram_mem [SRAM_DEPTH];
  always @(posedge clk) if (!if0.sram_wen) sram_mem[if0.sram_a] <= if0.sram_d;
  assign if0.sram_q = sram_mem[if0.sram_a];

  // ---------------- scoreboard / model state ----------------
  int         n_cmp, n_err;
  int         n_rel, cyc;
  logic       last_g;
  logic [7:0] ref_mem [SRAM_DEPTH];
  logic       exp_wen;
  logic [9:0] exp_a;
  logic [7:0] exp_d, rd_last;
  logic [8:0] exp_q [$];
  int         due_q [$];
  int         win;
  logic       obs_g0, obs_g1, obs_fg1, obs_rv0, obs_rv1, obs_wen;
  logic [7:0] obs_rdata;
  logic [9:0] obs_a;

  logic       pend [2];
  logic       pwe [2];
  logic [9:0] paddr [2];
  logic [7:0] pdata [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive();
    if0.req0 = pend[0]; if0.we0 = pwe[0]; if0.addr0 = paddr[0]; if0.wdata0 = pdata[0];
    if0.req1 = pend[1]; if0.we1 = pwe[1]; if0.addr1 = paddr[1]; if0.wdata1 = pdata[1];
  endtask

  // we_sel: 0 read, 1 write, 2 random
  task automatic rnd_req(input int r, input int we_sel);
    pend[r]  = 1'b1;
    pwe[r]   = (we_sel == 2) ? 1'($urandom_range(0, 1)) : 1'(we_sel);
    paddr[r] = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 15));
    pdata[r] = 8'($urandom_range(0, 255));
  endtask

  task automatic model_reset();
    n_rel   = 0;
    last_g  = 1'b1;
    exp_wen = 1'b1;
    exp_a   = '0;
    exp_d   = '0;
    rd_last = '0;
    exp_q.delete();
    due_q.delete();
    for (int i = 0; i < SRAM_DEPTH; i++) ref_mem[i] = INIT_V;
  endtask

  // One clock cycle: called at a falling edge after inputs are driven; checks, updates model.
  task automatic tick();
    logic       en, e0, e1, x0, x1, we;
    logic [8:0] ent;
    logic [9:0] a;
    logic [7:0] d;
    #1;
    en = (n_rel >= 1025);
    e0 = 1'b0;
    e1 = 1'b0;
    if (en) begin
      if (if0.req0 && if0.req1) begin
        e0 = last_g;
        e1 = !last_g;
      end else begin
        e0 = if0.req0;
        e1 = if0.req1;
      end
    end
    if (n_rel >= 1 && n_rel <= 1024) begin
      exp_wen = 1'b0;
      exp_a   = 10'(n_rel - 1);
      exp_d   = INIT_V;
    end
    check_eq("gnt0", if0.gnt0, e0);
    check_eq("gnt1", if0.gnt1, e1);
    check_eq("fix_gnt0", if_f.gnt0, en && if0.req0);
    check_eq("fix_gnt1", if_f.gnt1, en && if0.req1 && !if0.req0);
    check_eq("init_done", init_done, en);
    check_eq("fix_init_done", init_done_f, en);
    check_eq("state", st0, (n_rel >= 1024) ? ST_ARB : ST_INIT);
    check_eq("sram_wen", if0.sram_wen, exp_wen);
    check_eq("sram_a", if0.sram_a, exp_a);
    check_eq("sram_d", if0.sram_d, exp_d);
    x0 = 1'b0;
    x1 = 1'b0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      ent = exp_q.pop_front();
      void'(due_q.pop_front());
      rd_last = ent[7:0];
      x0 = !ent[8];
      x1 = ent[8];
    end
    check_eq("rvalid0", if0.rvalid0, x0);
    check_eq("rvalid1", if0.rvalid1, x1);
    check_eq("rdata", if0.rdata, rd_last);
    obs_g0 = if0.gnt0;   obs_g1 = if0.gnt1;   obs_fg1 = if_f.gnt1;
    obs_rv0 = if0.rvalid0; obs_rv1 = if0.rvalid1; obs_rdata = if0.rdata;
    obs_a = if0.sram_a;  obs_wen = if0.sram_wen;
    win = -1;
    if (!reset) begin
      model_reset();
    end else begin
      if (e0 || e1) begin
        last_g  = e1;
        we      = e1 ? if0.we1 : if0.we0;
        a       = e1 ? if0.addr1 : if0.addr0;
        d       = e1 ? if0.wdata1 : if0.wdata0;
        exp_a   = a;
        exp_d   = d;
        exp_wen = !we;
        if (we) ref_mem[a] = d;
        else begin
          exp_q.push_back({e1, ref_mem[a]});
          due_q.push_back(cyc + 2);
        end
        win = e1 ? 1 : 0;
      end else begin
        exp_wen = 1'b1;
      end
      n_rel++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic step();
    drive();
    tick();
    if (win >= 0) pend[win] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && (pend[0] || pend[1]); i++) step();
    check_eq("drain_done", {pend[0], pend[1]}, 2'b00);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic prev_rv0;
    n_cmp = 0; n_err = 0; cyc = 0;
    for (int r = 0; r < 2; r++) begin
      pend[r] = 1'b0; pwe[r] = 1'b0; paddr[r] = '0; pdata[r] = '0;
    end
    model_reset();
    reset = 1'b0;
    drive();
    repeat (2) @(negedge clk);

    // Reset held with requests pending: no grants, reset values on outputs.
    rnd_req(0, 1);
    rnd_req(1, 1);
    repeat (3) step();

    // Init sweep with both requesters waiting; they must be held off, not dropped.
    reset = 1'b1;
    repeat (1025) step();

    // Both requesters writing continuously: strict alternation starting with 0.
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("rr_order_gnt0", obs_g0, (i % 2) == 0);
      check_eq("rr_order_gnt1", obs_g1, (i % 2) == 1);
      for (int r = 0; r < 2; r++) if (!pend[r]) rnd_req(r, 1);
    end
    drain();

    // Write 37 <= 05 then read it back next grant.
    pend[0] = 1'b1; pwe[0] = 1'b1; paddr[0] = 10'd37; pdata[0] = 8'h05;
    step();
    pend[0] = 1'b1; pwe[0] = 1'b0; paddr[0] = 10'd37; pdata[0] = 8'h00;
    step();
    step();
    step();
    check_eq("wr_rd37_rvalid0", obs_rv0, 1'b1);
    check_eq("wr_rd37_rdata", obs_rdata, 8'h05);

    // Both held high for 4 cycles: fixed-priority instance never grants 1 until req0 drops.
    for (int i = 0; i < 4; i++) begin
      for (int r = 0; r < 2; r++) if (!pend[r]) rnd_req(r, 2);
      step();
      check_eq("fix_hold_gnt1", obs_fg1, 1'b0);
    end
    pend[0] = 1'b0;
    if (!pend[1]) rnd_req(1, 2);
    step();
    check_eq("fix_drop_gnt1", obs_fg1, 1'b1);
    drain();

    // Alternating reads from both requesters every cycle.
    prev_rv0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      for (int r = 0; r < 2; r++) if (!pend[r]) rnd_req(r, 0);
      step();
      if (i >= 2) begin
        check_eq("alt_one_rvalid", obs_rv0 ^ obs_rv1, 1'b1);
        if (i >= 3) check_eq("alt_rvalid0", obs_rv0, !prev_rv0);
      end
      prev_rv0 = obs_rv0;
    end
    drain();

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      for (int r = 0; r < 2; r++) if (!pend[r] && $urandom_range(0, 99) < 60) rnd_req(r, 2);
      step();
    end
    drain();
    repeat (3) step();

    // Read granted to requester 1, reset asserted the next cycle: no rvalid, sweep restarts.
    pend[1] = 1'b1; pwe[1] = 1'b0; paddr[1] = 10'd5; pdata[1] = 8'h00;
    step();
    check_eq("rst_read_gnt1", obs_g1, 1'b1);
    reset = 1'b0;
    step();
    step();
    check_eq("rst_no_rvalid1", obs_rv1, 1'b0);
    step();
    reset = 1'b1;
    step();
    step();
    check_eq("restart_sram_a", obs_a, 10'd0);
    check_eq("restart_sram_wen", obs_wen, 1'b0);
    repeat (1024) step();

    for (int i = 0; i < 40; i++) begin
      for (int r = 0; r < 2; r++) if (!pend[r] && $urandom_range(0, 99) < 70) rnd_req(r, 2);
      step();
    end
    drain();
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cle_sram_arb.md
CLE_SRAM_ARB -- requirements
Module: cle_sram_arb

Interface
REQ-001 Parameter: ARB_MODE, 0, 0 = round-robin between requesters, 1 = fixed priority to requester 0.
REQ-002 Parameter: INIT_VAL, 8'h00, value written to every SRAM word during the init sweep.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-low reset.
REQ-005 Port: req0 / req1  input  1 each  access request, held until granted.
REQ-006 Port: we0 / we1  input  1 each  1 = write, 0 = read.
REQ-007 Port: addr0 / addr1  input  10 each  word address (row*32+col).
REQ-008 Port: wdata0 / wdata1  input  8 each  write data.
REQ-009 Port: gnt0 / gnt1  output  1 each  combinational grant, same cycle as accepted request.
REQ-010 Port: rvalid0 / rvalid1  output  1 each  one-cycle pulse, read data valid for that requester.
REQ-011 Port: rdata  output  8  registered read data, shared by both requesters.
REQ-012 Port: sram_a  output  10  SRAM address, registered.
REQ-013 Port: sram_d  output  8  SRAM write data, registered.
REQ-014 Port: sram_wen  output  1  SRAM write enable, active-low, registered.
REQ-015 Port: sram_q  input  8  SRAM read data, valid the cycle after sram_a is presented.
REQ-016 Port: init_done  output  1  high once the init sweep has completed.

Function
REQ-017 FSM states: INIT, ARB; reset enters INIT; INIT goes to ARB after address 1023 is written; ARB is terminal until reset.
REQ-018 INIT: 10-bit counter from 0; each cycle drive sram_a=counter, sram_d=INIT_VAL, sram_wen=0; exactly 1024 writes, no wrap.
REQ-019 During INIT: gnt0=gnt1=0, rvalid0=rvalid1=0, init_done=0; requests are held off, not dropped.
REQ-020 ARB: at most one grant per cycle; grant only when the requester's req=1.
REQ-021 ARB_MODE=0: single requester is granted; both requesting grants the one not granted most recently; pointer updates only on a grant; after reset requester 0 wins the first tie.
REQ-022 ARB_MODE=1: req0 always wins; req1 granted only when req0=0.
REQ-023 Grant in cycle T registers addr/wdata/~we of the winner onto sram_a/sram_d/sram_wen at end of T.
REQ-024 Read granted in T: sram_q sampled at end of T+1; rdata updated and rvalidN pulsed in T+2 (latency 2).
REQ-025 Read tag pipeline is two stages deep; back-to-back reads from either requester are supported every cycle.
REQ-026 No grant in ARB: sram_wen=1, sram_a and sram_d hold last values.
REQ-027 Write-then-read to the same address in consecutive grants returns the new data; no forwarding logic is required.
REQ-028 rdata holds its value between rvalid pulses.

Reset
REQ-029 reset=0 at any clock edge, including mid-sweep or with reads in flight: state=INIT, counter=0, RR pointer favors requester 0, read tags cleared (in-flight rvalid suppressed), sram_wen=1, sram_a=0, sram_d=0, rdata=0, init_done=0.
REQ-030 First INIT write occurs in the first cycle after reset returns high.

Structure
REQ-031 Shared package cle_pkg holds ADDR_W=10, DATA_W=8, SRAM_DEPTH=1024, and the FSM state enumeration.
REQ-032 One sub-module cle_rr_pick: two-input round-robin / fixed-priority picker with pointer register.
REQ-033 Target 150-300 lines total RTL.

Verification
REQ-034 Reset release, no requests -> 1024 writes of INIT_VAL to addresses 0..1023 in order, init_done rises on cycle 1025, no grants before then.
REQ-035 ARB_MODE=0, req0 and req1 held high, both writing, for 6 cycles -> gnt order 0,1,0,1,0,1; sram_wen=0 each following cycle.
REQ-036 req0 write addr 10'd37 data 8'h05, next cycle read of 37 -> rvalid0 two cycles after read grant, rdata=8'h05.
REQ-037 ARB_MODE=1, req0 and req1 high for 4 cycles -> gnt1 never asserted; gnt1 asserted in the first cycle req0 drops.
REQ-038 Read granted to req1, reset asserted one cycle later -> no rvalid1 pulse; INIT sweep restarts at address 0.
REQ-039 Alternating reads req0/req1 every cycle -> rvalid alternates 0,1,0,1 with correct per-address rdata, latency 2.
